// File: rtl/stdp_update.sv
// STDP weight update engine: after each gamma cycle, read-modify-write every synapse of the winner.
// Optional STDP_BACKOFF_EN: non-spiking inputs of a firing column are depressed instead of held.
`ifndef NEURONS_PER_LAYER
`define NEURONS_PER_LAYER 4
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 16
`endif

module stdp_update #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = `NEURONS_PER_LAYER,
  parameter int TW          = $clog2(`TIME_PERIOD),
  parameter int WB          = 3,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int AW = ((NUM_NEURONS * NUM_INPUTS) > 1) ? $clog2(NUM_NEURONS * NUM_INPUTS) : 1,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     start,
  input  logic                     output_spike,
  input  logic [TW-1:0]            output_spike_time,
  input  logic [NW-1:0]            winning_neuron,
  input  logic [NUM_INPUTS-1:0]    in_spiked,
  input  logic [NUM_INPUTS*TW-1:0] in_times,
  output logic [AW-1:0]            rd_addr,
  input  logic [WB-1:0]            rd_data,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [WB-1:0]            wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [WB-1:0] WMAX = {WB{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, MODIFY, DONE} state_t;

  state_t                  state, next_state;
  logic [IW-1:0]           idx;
  logic                    spike_q;
  logic [TW-1:0]           t_out_q;
  logic [NW-1:0]           win_q;
  logic [NUM_INPUTS-1:0]   spiked_q;
  logic [NUM_INPUTS*TW-1:0] times_q;
  logic [AW-1:0]           addr;
  logic [TW-1:0]           t_in;
  logic                    last;
  logic [WB-1:0]           w_new;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= next_state;
  end

  // Inputs are frozen at start so the whole pass sees one consistent gamma cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      idx      <= '0;
      spike_q  <= 1'b0;
      t_out_q  <= '0;
      win_q    <= '0;
      spiked_q <= '0;
      times_q  <= '0;
    end else if (state == IDLE && start) begin
      idx      <= '0;
      spike_q  <= output_spike;
      t_out_q  <= output_spike_time;
      win_q    <= winning_neuron;
      spiked_q <= in_spiked;
      times_q  <= in_times;
    end else if (state == MODIFY) begin
      idx <= last ? '0 : idx + IW'(1);
    end
  end

  assign last = (idx == IW'(NUM_INPUTS - 1));
  assign addr = AW'(win_q) * AW'(NUM_INPUTS) + AW'(idx);
  assign t_in = times_q[idx*TW +: TW];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = output_spike ? READ : DONE;
      READ:    next_state = MODIFY;
      MODIFY:  next_state = last ? DONE : READ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Saturating potentiate/depress; rd_data is the weight addressed during the preceding READ.
  always_comb begin
    w_new = rd_data;
    if (spiked_q[idx]) begin
      if (t_in <= t_out_q) w_new = (rd_data == WMAX) ? rd_data : rd_data + WB'(1);
      else                 w_new = (rd_data == '0)   ? rd_data : rd_data - WB'(1);
    end else begin
`ifdef STDP_BACKOFF_EN
      if (spike_q) w_new = (rd_data == '0) ? rd_data : rd_data - WB'(1);
`else
      w_new = rd_data;
`endif
    end
  end

  assign rd_addr = (state == READ) ? addr : '0;
  assign wr_en   = (state == MODIFY);
  assign wr_addr = wr_en ? addr : '0;
  assign wr_data = wr_en ? w_new : '0;
  assign busy    = (state == READ) || (state == MODIFY);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_stdp_update.sv
// Scoreboard bench for stdp_update: directed passes against a behavioural weight RAM.
module tb_stdp_update;

  localparam int NI = 16;
  localparam int NN = 4;
  localparam int TW = 4;
  localparam int WB = 3;
  localparam int AW = 6;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             start = 1'b0;
  logic             output_spike = 1'b0;
  logic [TW-1:0]    output_spike_time = '0;
  logic [NW-1:0]    winning_neuron = '0;
  logic [NI-1:0]    in_spiked = '0;
  logic [NI*TW-1:0] in_times = '0;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [WB-1:0]    rd_data, wr_data;
  logic             wr_en, busy, done;

  always #5 clk = ~clk;

  stdp_update #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .TW(TW), .WB(WB)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .output_spike(output_spike),
    .output_spike_time(output_spike_time), .winning_neuron(winning_neuron),
    .in_spiked(in_spiked), .in_times(in_times), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // Hand-computed vector table, winner spike time 5.
  int tab_spk[NI] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1};
  int tab_t[NI]   = '{3, 9, 2, 0, 5, 6, 0, 15, 0, 7, 4, 6, 5, 12, 1, 1};
  int tab_w[NI]   = '{4, 0, 7, 3, 2, 5, 6, 1, 0, 7, 7, 1, 6, 3, 5, 0};
`ifdef STDP_BACKOFF_EN
  int tab_exp[NI] = '{5, 0, 7, 2, 3, 4, 7, 0, 0, 6, 7, 0, 7, 2, 4, 1};
`else
  int tab_exp[NI] = '{5, 0, 7, 3, 3, 4, 7, 0, 0, 7, 7, 0, 7, 2, 5, 1};
`endif

  logic [WB-1:0] mem [0:NN*NI-1];
  logic [WB-1:0] init_mem [0:NN*NI-1];
  logic          load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NN*NI; k++) mem[k] <= init_mem[k];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_lat_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (rst_l) begin
      if (wr_en) begin
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
        end else begin
          check_output("wr_addr", int'(wr_addr), exp_addr_q.pop_front());
          check_output("wr_data", int'(wr_data), exp_data_q.pop_front());
        end
      end
      if (done) begin
        done_count++;
        if (exp_lat_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          check_output("done_latency", cyc - start_cyc + 1, exp_lat_q.pop_front());
        end
      end
    end
  end

  task automatic apply_stimulus(input int win, input int spike, input int exp_lat, input int n_writes);
    for (int i = 0; i < n_writes; i++) begin
      exp_addr_q.push_back(win * NI + i);
      exp_data_q.push_back(tab_exp[i]);
    end
    if (exp_lat > 0) exp_lat_q.push_back(exp_lat);
    @(negedge clk);
    output_spike      = spike[0];
    output_spike_time = TW'(5);
    winning_neuron    = NW'(win);
    for (int i = 0; i < NI; i++) begin
      in_spiked[i]        = tab_spk[i][0];
      in_times[i*TW +: TW] = TW'(tab_t[i]);
    end
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen;
    n    = done_count;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done_count != n) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no done in 200 cycles, expected done", name);
    end
  endtask

  initial begin
    int saved;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++) init_mem[n*NI + i] = WB'(tab_w[i]);
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1 load = 1'b0;

    check_output("rst_wr_en", int'(wr_en), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_rd_addr", int'(rd_addr), 0);
    check_output("rst_wr_addr", int'(wr_addr), 0);
    check_output("rst_wr_data", int'(wr_data), 0);
    @(negedge clk);
    rst_l = 1'b1;

    // Full pass on neuron 2, then a start pulse during DONE that must be lost.
    apply_stimulus(2, 1, 33, 16);
    wait_done("pass_win2");
    saved             = done_count;
    start             = 1'b1;
    output_spike      = 1'b1;
    winning_neuron    = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_output("done_lost_busy", int'(busy), 0);
    check_output("done_lost_count", done_count, saved);
    check_output("queue_empty_win2", exp_addr_q.size(), 0);
    check_output("mem_addr32", int'(mem[32]), 5);

    // No output spike: done next cycle, no writes.
    apply_stimulus(1, 0, 1, 0);
    wait_done("no_spike");
    repeat (3) @(negedge clk);
    check_output("queue_empty_nospike", exp_addr_q.size(), 0);

    // Second start and a changed winner mid-pass must be ignored.
    apply_stimulus(0, 1, 33, 16);
    while (cyc < start_cyc + 9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start          = 1'b1;
    winning_neuron = NW'(1);
    output_spike   = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check_output("busy_mid_pass", int'(busy), 1);
    wait_done("pass_win0");
    check_output("queue_empty_win0", exp_addr_q.size(), 0);

    // Reset in cycle 12 (MODIFY of input 5) abandons the pass.
    apply_stimulus(1, 1, 0, 5);
    while (cyc < start_cyc + 11) begin
      @(posedge clk);
      #1;
    end
    check_output("pre_reset_wr_en", int'(wr_en), 1);
    check_output("pre_reset_wr_addr", int'(wr_addr), 21);
    rst_l = 1'b0;
    #1;
    check_output("mid_rst_wr_en", int'(wr_en), 0);
    check_output("mid_rst_busy", int'(busy), 0);
    check_output("mid_rst_done", int'(done), 0);
    check_output("mid_rst_rd_addr", int'(rd_addr), 0);
    check_output("mid_rst_wr_addr", int'(wr_addr), 0);
    check_output("mid_rst_wr_data", int'(wr_data), 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    check_output("queue_empty_reset", exp_addr_q.size(), 0);
    check_output("mem_addr21_kept", int'(mem[21]), 5);
    check_output("mem_addr20_written", int'(mem[20]), 3);

    // Full pass after reset on neuron 3.
    apply_stimulus(3, 1, 33, 16);
    wait_done("pass_win3");
    repeat (2) @(negedge clk);
    check_output("queue_empty_win3", exp_addr_q.size(), 0);
    check_output("lat_queue_empty", exp_lat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
